ucode_seq: RTL and testbench
============================

UCODE_SEQ -- requirements
Module: ucode_seq

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock.
REQ-002 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: run  input  1  level; 1 = execute program, 0 = return to program-load mode.
REQ-004 SHALL have: prog_valid  input  1  one instruction byte presented to instruction memory this cycle.
REQ-005 SHALL have: instr  input  8  instruction read from memory at pc; [7:4] opcode, [3:0] operand.
REQ-006 SHALL have: zero  input  1  datapath accumulator-zero flag.
REQ-007 SHALL have: state  output  1  0 = load mode, 1 = run mode; drives memory state.
REQ-008 SHALL have: load  output  1  memory write enable.
REQ-009 SHALL have: pc  output  4  program counter; drives memory address.
REQ-010 SHALL have: alu_en  output  1  accumulator update strobe.
REQ-011 SHALL have: alu_op  output  3  0 pass-imm, 1 add, 2 sub, 3 and, 4 or, 5 xor.
REQ-012 SHALL have: imm  output  4  operand field of the executing instruction.
REQ-013 SHALL have: out_en  output  1  output-port latch strobe.
REQ-014 SHALL have: halted  output  1  program reached HLT.
REQ-015 SHALL have: full  output  1  load pointer exhausted.

Function
REQ-016 FSM states SHALL be LOAD, FETCH, EXEC, HALT; state output = 0 only in LOAD.
REQ-017 In LOAD, load SHALL = prog_valid & ~run & ~full (combinational); pc SHALL increment on each such cycle.
REQ-018 Load pointer SHALL start at 1; address 0 is never written and reads as NOP.
REQ-019 A write at pc=15 SHALL set full and leave pc at 15; further prog_valid SHALL be ignored until LOAD is re-entered.
REQ-020 LOAD with run=1 SHALL go to FETCH next cycle with pc=1; run takes priority over prog_valid that cycle (no write).
REQ-021 FETCH SHALL latch instr into an 8-bit IR and go to EXEC; all strobes are 0 in FETCH.
REQ-022 EXEC SHALL drive strobes registered from IR for exactly one cycle; every instruction takes 2 cycles.
REQ-023 Opcodes: 0 NOP; 1 LDI (alu_op 0); 2 ADD; 3 SUB; 4 AND; 5 OR; 6 XOR (alu_en=1); 7 JMP (pc<=imm); 8 JZ (pc<=imm if zero else pc+1); 9 OUT (out_en=1); F HLT; A-E treated as NOP.
REQ-024 JZ SHALL sample zero during its EXEC cycle, i.e. the flag from the previous instruction.
REQ-025 Non-branch EXEC SHALL set pc <= pc+1 modulo 16 (15 wraps to 0), then return to FETCH.
REQ-026 HLT SHALL go to HALT: halted=1, pc frozen, strobes 0, until run=0.
REQ-027 run=0 in FETCH, EXEC or HALT SHALL go to LOAD next cycle with pc=1, full=0, halted=0; an EXEC in progress still issues its strobes that cycle.
REQ-028 imm SHALL equal IR[3:0] whenever a strobe is asserted.

Reset
REQ-029 rst SHALL force state LOAD, pc=1, IR=0, full=0, halted=0, alu_en=0, out_en=0, alu_op=0, imm=0, regardless of clk.
REQ-030 rst asserted mid-load or mid-execution SHALL abort with no further load or strobe pulse; memory contents are the memory's own concern.

Structure
REQ-031 Opcode codes, alu_op codes and FSM state encodings SHALL live in the shared shmcp_defs constants file used by the datapath.
REQ-032 Opcode-to-control-word decode SHALL be a combinational sub-module ucode_rom (opcode in; alu_en, alu_op, out_en, jmp, jz, hlt out).

Verification
REQ-033 Reset, then prog_valid for 3 cycles with bytes 0x15, 0x23, 0x90 -> load pulses at pc=1,2,3; pc=4; state=0.
REQ-034 run=1 after that program -> alu_en with imm=5 op0, then imm=3 op1, then out_en; each 2 cycles apart; pc wraps through 0 with no strobe at address 0.
REQ-035 15 consecutive prog_valid -> full=1 after the write at pc=15; 16th prog_valid -> load=0, pc stays 15.
REQ-036 Program 0x10, 0x8F, ..., 0xF0 at 15, with zero=1 -> JZ sets pc=15, then HLT -> halted=1, pc frozen at 15.
REQ-037 Drop run during EXEC of ADD -> alu_en pulses once, then state=0, pc=1 next cycle.
REQ-038 Assert rst mid-run in FETCH -> all outputs at reset values immediately; no strobe follows.

Source files
------------

// File: rtl/shmcp_defs.sv
// Constants shared by the microcode sequencer and the datapath: opcodes, ALU op codes and FSM encodings.
package shmcp_defs;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    typedef struct packed {
        logic       alu_en;
        logic [2:0] alu_op;
        logic       out_en;
        logic       jmp;
        logic       jz;
        logic       hlt;
    } ctrl_t;

endpackage

// File: rtl/ucode_rom.sv
// Purely combinational opcode-to-control-word decode; unlisted opcodes decode as NOP.
module ucode_rom
    import shmcp_defs::*;
(
    input  logic [3:0] opcode,
    output logic       alu_en,
    output logic [2:0] alu_op,
    output logic       out_en,
    output logic       jmp,
    output logic       jz,
    output logic       hlt
);

    always_comb begin
        alu_en = 1'b0;
        alu_op = ALU_PASS;
        out_en = 1'b0;
        jmp    = 1'b0;
        jz     = 1'b0;
        hlt    = 1'b0;
        case (opcode)
            OP_LDI: begin alu_en = 1'b1; alu_op = ALU_PASS; end
            OP_ADD: begin alu_en = 1'b1; alu_op = ALU_ADD;  end
            OP_SUB: begin alu_en = 1'b1; alu_op = ALU_SUB;  end
            OP_AND: begin alu_en = 1'b1; alu_op = ALU_AND;  end
            OP_OR:  begin alu_en = 1'b1; alu_op = ALU_OR;   end
            OP_XOR: begin alu_en = 1'b1; alu_op = ALU_XOR;  end
            OP_JMP: jmp    = 1'b1;
            OP_JZ:  jz     = 1'b1;
            OP_OUT: out_en = 1'b1;
            OP_HLT: hlt    = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ucode_seq.sv
// Two-cycle microcode sequencer: LOAD writes program bytes at pc, then FETCH/EXEC per instruction until HLT.
// Strobes are registered on the FETCH->EXEC edge so they last exactly one EXEC cycle.
module ucode_seq
    import shmcp_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       prog_valid,
    input  logic [7:0] instr,
    input  logic       zero,
    output logic       state,
    output logic       load,
    output logic [3:0] pc,
    output logic       alu_en,
    output logic [2:0] alu_op,
    output logic [3:0] imm,
    output logic       out_en,
    output logic       halted,
    output logic       full
);

    logic [1:0] st;
    logic [7:0] ir;
    logic [3:0] rom_opcode;
    ctrl_t      ctl;

    // In FETCH the decode looks at the incoming byte so the strobes can be registered; in EXEC it looks at IR.
    assign rom_opcode = (st == ST_FETCH) ? instr[7:4] : ir[7:4];

    ucode_rom u_rom (
        .opcode (rom_opcode),
        .alu_en (ctl.alu_en),
        .alu_op (ctl.alu_op),
        .out_en (ctl.out_en),
        .jmp    (ctl.jmp),
        .jz     (ctl.jz),
        .hlt    (ctl.hlt)
    );

    assign state = (st != ST_LOAD);
    assign load  = (st == ST_LOAD) & prog_valid & ~run & ~full & ~rst;
    assign imm   = ir[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= ST_LOAD;
            pc     <= 4'd1;
            ir     <= 8'h00;
            full   <= 1'b0;
            halted <= 1'b0;
            alu_en <= 1'b0;
            alu_op <= ALU_PASS;
            out_en <= 1'b0;
        end else begin
            alu_en <= 1'b0;
            alu_op <= ALU_PASS;
            out_en <= 1'b0;
            case (st)
                ST_LOAD: begin
                    if (run) begin
                        st <= ST_FETCH;
                        pc <= 4'd1;
                    end else if (prog_valid && !full) begin
                        if (pc == 4'd15) full <= 1'b1;
                        else             pc   <= pc + 4'd1;
                    end
                end
                ST_FETCH: begin
                    if (!run) begin
                        st     <= ST_LOAD;
                        pc     <= 4'd1;
                        full   <= 1'b0;
                        halted <= 1'b0;
                    end else begin
                        ir     <= instr;
                        st     <= ST_EXEC;
                        alu_en <= ctl.alu_en;
                        alu_op <= ctl.alu_op;
                        out_en <= ctl.out_en;
                    end
                end
                ST_EXEC: begin
                    if (!run) begin
                        st     <= ST_LOAD;
                        pc     <= 4'd1;
                        full   <= 1'b0;
                        halted <= 1'b0;
                    end else if (ctl.hlt) begin
                        st     <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        st <= ST_FETCH;
                        // zero here is the flag left by the previous instruction
                        if (ctl.jmp || (ctl.jz && zero)) pc <= ir[3:0];
                        else                             pc <= pc + 4'd1;
                    end
                end
                ST_HALT: begin
                    if (!run) begin
                        st     <= ST_LOAD;
                        pc     <= 4'd1;
                        full   <= 1'b0;
                        halted <= 1'b0;
                    end
                end
                default: st <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_ucode_seq.sv
module tb_ucode_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       prog_valid = 1'b0;
    logic [7:0] instr;
    logic       zero = 1'b0;
    logic       state, load, alu_en, out_en, halted, full;
    logic [3:0] pc, imm;
    logic [2:0] alu_op;

    logic [7:0] mem [16];
    logic [7:0] wd = 8'h00;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic       run, pv;
        logic [7:0] wd;
        logic       st, ld;
        logic [3:0] pc;
        logic       ae;
        logic [2:0] op;
        logic [3:0] imm;
        logic       oe, h, f;
    } vec_t;

    vec_t tab [11];

    always #5 clk = ~clk;

    ucode_seq dut (
        .clk(clk), .rst(rst), .run(run), .prog_valid(prog_valid), .instr(instr),
        .zero(zero), .state(state), .load(load), .pc(pc), .alu_en(alu_en),
        .alu_op(alu_op), .imm(imm), .out_en(out_en), .halted(halted), .full(full)
    );

    // Program memory model: written by load, address 0 always reads as NOP.
    assign instr = (pc == 4'd0) ? 8'h00 : mem[pc];
    always @(posedge clk) if (load) mem[pc] <= wd;

    function automatic vec_t mk(input logic r, input logic p, input logic [7:0] w,
                                input logic s, input logic l, input logic [3:0] c,
                                input logic a, input logic [2:0] o, input logic [3:0] i,
                                input logic e, input logic h, input logic f);
        vec_t v;
        v.run = r; v.pv = p; v.wd = w; v.st = s; v.ld = l; v.pc = c;
        v.ae = a; v.op = o; v.imm = i; v.oe = e; v.h = h; v.f = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic chk_core(input string tag, input logic s, input logic [3:0] c,
                            input logic a, input logic e, input logic h);
        check({tag, ".state"},  {7'd0, state},  {7'd0, s});
        check({tag, ".pc"},     {4'd0, pc},     {4'd0, c});
        check({tag, ".alu_en"}, {7'd0, alu_en}, {7'd0, a});
        check({tag, ".out_en"}, {7'd0, out_en}, {7'd0, e});
        check({tag, ".halted"}, {7'd0, halted}, {7'd0, h});
    endtask

    task automatic drive(input logic r, input logic p, input logic [7:0] w, input logic z);
        run = r; prog_valid = p; wd = w; zero = z;
        #1;
    endtask

    function automatic logic [7:0] prog_byte(input int a);
        case (a)
            1:  return 8'h10;
            2:  return 8'h8F;
            15: return 8'hF0;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // Reset values while rst held
        @(negedge clk); #1;
        chk_core("reset", 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
        check("reset.full", {7'd0, full}, 8'd0);
        check("reset.alu_op", {5'd0, alu_op}, 8'd0);
        check("reset.imm", {4'd0, imm}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load 0x15,0x23,0x90 then run the first three instructions
        tab[0]  = mk(0, 1, 8'h15, 0, 1, 4'd1, 0, 3'd0, 4'd0, 0, 0, 0);
        tab[1]  = mk(0, 1, 8'h23, 0, 1, 4'd2, 0, 3'd0, 4'd0, 0, 0, 0);
        tab[2]  = mk(0, 1, 8'h90, 0, 1, 4'd3, 0, 3'd0, 4'd0, 0, 0, 0);
        tab[3]  = mk(0, 0, 8'h00, 0, 0, 4'd4, 0, 3'd0, 4'd0, 0, 0, 0);
        tab[4]  = mk(1, 1, 8'hAA, 0, 0, 4'd4, 0, 3'd0, 4'd0, 0, 0, 0);
        tab[5]  = mk(1, 0, 8'h00, 1, 0, 4'd1, 0, 3'd0, 4'd0, 0, 0, 0);
        tab[6]  = mk(1, 0, 8'h00, 1, 0, 4'd1, 1, 3'd0, 4'd5, 0, 0, 0);
        tab[7]  = mk(1, 0, 8'h00, 1, 0, 4'd2, 0, 3'd0, 4'd0, 0, 0, 0);
        tab[8]  = mk(1, 0, 8'h00, 1, 0, 4'd2, 1, 3'd1, 4'd3, 0, 0, 0);
        tab[9]  = mk(1, 0, 8'h00, 1, 0, 4'd3, 0, 3'd0, 4'd0, 0, 0, 0);
        tab[10] = mk(1, 0, 8'h00, 1, 0, 4'd3, 0, 3'd0, 4'd0, 1, 0, 0);
        for (int i = 0; i < 11; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tab[i].run, tab[i].pv, tab[i].wd, 1'b0);
            chk_core(t, tab[i].st, tab[i].pc, tab[i].ae, tab[i].oe, tab[i].h);
            check({t, ".load"},   {7'd0, load},   {7'd0, tab[i].ld});
            check({t, ".alu_op"}, {5'd0, alu_op}, {5'd0, tab[i].op});
            check({t, ".full"},   {7'd0, full},   {7'd0, tab[i].f});
            if (tab[i].ae || tab[i].oe) check({t, ".imm"}, {4'd0, imm}, {4'd0, tab[i].imm});
            @(negedge clk);
        end

        // NOPs at 4..15, wrap through 0 with no strobe
        for (int k = 4; k <= 16; k++) begin
            logic [3:0] a;
            a = 4'(k);
            drive(1, 0, 8'h00, 0);
            chk_core($sformatf("nopF%0d", a), 1'b1, a, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            drive(1, 0, 8'h00, 0);
            chk_core($sformatf("nopE%0d", a), 1'b1, a, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1, 0, 8'h00, 0); @(negedge clk);
        drive(1, 0, 8'h00, 0);
        chk_core("wrap_ldi", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        check("wrap_ldi.imm", {4'd0, imm}, 8'd5);
        @(negedge clk);
        drive(1, 0, 8'h00, 0); @(negedge clk);

        // Drop run during EXEC of ADD: strobe still issued, then LOAD with pc=1
        drive(0, 0, 8'h00, 0);
        chk_core("drop_add", 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        check("drop_add.alu_op", {5'd0, alu_op}, 8'd1);
        @(negedge clk);
        drive(0, 0, 8'h00, 0);
        chk_core("drop_after", 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Fill all 15 addresses; extra prog_valid ignored once full
        for (int i = 1; i <= 15; i++) begin
            drive(0, 1, prog_byte(i), 0);
            check($sformatf("fill%0d.load", i), {7'd0, load}, 8'd1);
            check($sformatf("fill%0d.pc", i), {4'd0, pc}, 8'(i));
            check($sformatf("fill%0d.full", i), {7'd0, full}, 8'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 8'h55, 0);
            check($sformatf("over%0d.load", i), {7'd0, load}, 8'd0);
            check($sformatf("over%0d.pc", i), {4'd0, pc}, 8'd15);
            check($sformatf("over%0d.full", i), {7'd0, full}, 8'd1);
            @(negedge clk);
        end

        // JZ taken with zero=1, then HLT at 15
        drive(1, 0, 8'h00, 1); @(negedge clk);
        drive(1, 0, 8'h00, 1); chk_core("jz_f1", 1, 4'd1, 0, 0, 0); @(negedge clk);
        drive(1, 0, 8'h00, 1); chk_core("jz_e1", 1, 4'd1, 1, 0, 0); @(negedge clk);
        drive(1, 0, 8'h00, 1); chk_core("jz_f2", 1, 4'd2, 0, 0, 0); @(negedge clk);
        drive(1, 0, 8'h00, 1); chk_core("jz_e2", 1, 4'd2, 0, 0, 0); @(negedge clk);
        drive(1, 0, 8'h00, 1); chk_core("jz_f15", 1, 4'd15, 0, 0, 0); @(negedge clk);
        drive(1, 0, 8'h00, 1); chk_core("hlt_e", 1, 4'd15, 0, 0, 0); @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 8'h00, 1);
            chk_core($sformatf("halt%0d", i), 1, 4'd15, 0, 0, 1);
            @(negedge clk);
        end
        drive(0, 0, 8'h00, 1); @(negedge clk);
        drive(0, 0, 8'h00, 0);
        chk_core("halt_exit", 0, 4'd1, 0, 0, 0);
        check("halt_exit.full", {7'd0, full}, 8'd0);
        @(negedge clk);

        // JZ not taken with zero=0; drop run in FETCH
        drive(1, 0, 8'h00, 0); @(negedge clk);
        for (int i = 0; i < 4; i++) begin drive(1, 0, 8'h00, 0); @(negedge clk); end
        drive(0, 0, 8'h00, 0);
        chk_core("jnz_f3", 1, 4'd3, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 8'h00, 0);
        chk_core("fetch_drop", 0, 4'd1, 0, 0, 0);
        @(negedge clk);

        // rst asserted in FETCH of an LDI: immediate reset values, no strobe afterwards
        drive(1, 0, 8'h00, 0); @(negedge clk);
        drive(1, 0, 8'h00, 0);
        chk_core("rst_pre", 1, 4'd1, 0, 0, 0);
        rst = 1'b1; run = 1'b0; prog_valid = 1'b1;
        #1;
        chk_core("rst_now", 0, 4'd1, 0, 0, 0);
        check("rst_now.load", {7'd0, load}, 8'd0);
        @(negedge clk);
        rst = 1'b0; prog_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 8'h00, 0);
            chk_core($sformatf("rst_after%0d", i), 0, 4'd1, 0, 0, 0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
